// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch path: opcodes, field positions,
// fetch FSM states and the buffered fetch entry.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int F7B5_BIT = 30;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the decode-facing
// instruction handshake. master = fetch unit, slave = memory/decode side.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc, pc_plus4, op, funct3, funct7b5,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc, pc_plus4, op, funct3, funct7b5,
        output instr_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instr, pc} entries. Flush beats push;
// a pop in the flush cycle is simply absorbed by the flush.
module fetch_buffer #(
    parameter  int DEPTH  = 2,
    parameter  int DATA_W = 64,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps at most one imem request in flight,
// buffers responses for decode and squashes wrong-path work on redirect.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        misaligned,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_pc_inflight, w_pc_inflight_nxt;
    logic         r_misaligned;

    logic         w_req_hs;
    logic         w_push;
    logic         w_pop;
    logic         w_in_flight;
    logic [CNT_W-1:0] w_count;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_wentry;
    fetch_entry_t w_head;

    // Only REQ can hold an outstanding slot, so the buffer count alone bounds issue.
    assign bus.imem_req_valid = ~reset & (r_state == REQ) & (w_count < CNT_W'(BUF_DEPTH));
    assign bus.imem_req_addr  = r_pc;
    assign w_req_hs           = bus.imem_req_valid & bus.imem_req_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pc_inflight_nxt = r_pc_inflight;
        w_push            = 1'b0;
        w_in_flight       = 1'b0;
        unique case (r_state)
            REQ: begin
                if (w_req_hs) begin
                    w_state_nxt       = WAIT;
                    w_pc_inflight_nxt = r_pc;
                    w_pc_nxt          = r_pc + 32'd4;
                    w_in_flight       = 1'b1;
                end
            end
            WAIT: begin
                w_in_flight = ~bus.imem_rsp_valid;
                if (bus.imem_rsp_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DISCARD: begin
                w_in_flight = ~bus.imem_rsp_valid;
                if (bus.imem_rsp_valid) w_state_nxt = REQ;
            end
            default: w_state_nxt = REQ;
        endcase
        // Redirect wins: an outstanding request must drain through DISCARD.
        if (pc_src) begin
            w_pc_nxt    = word_align(pc_target);
            w_push      = 1'b0;
            w_state_nxt = w_in_flight ? DISCARD : REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= REQ;
            r_pc          <= word_align(RESET_PC);
            r_pc_inflight <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pc_inflight <= w_pc_inflight_nxt;
            if (pc_src && (pc_target[1:0] != 2'b00)) r_misaligned <= 1'b1;
        end
    end

    assign misaligned     = r_misaligned;
    assign w_pop          = bus.instr_valid & bus.instr_ready;
    assign w_wentry.instr = bus.imem_rsp_data;
    assign w_wentry.pc    = r_pc_inflight;

    fetch_buffer #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W ($bits(fetch_entry_t))
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (pc_src),
        .i_wdata (w_wentry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.instr_valid = ~w_empty;
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
    assign bus.pc_plus4    = w_head.pc + 32'd4;
    assign bus.op          = w_head.instr[OP_MSB:OP_LSB];
    assign bus.funct3      = w_head.instr[F3_MSB:F3_LSB];
    assign bus.funct7b5    = w_head.instr[F7B5_BIT];

    // Buffer full is already implied by the count check on issue; kept visible for debug.
    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem model feeds a scoreboard at
// request time; every decode pop is compared against the scoreboard head.
module tb_fetch_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        misaligned;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .misaligned (misaligned),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    fetch_entry_t sb [$];
    logic [31:0]  req_log [$];
    logic [31:0]  pop_pc [$];
    logic [31:0]  pop_instr [$];
    logic [31:0]  pop_p4 [$];
    logic [6:0]   pop_op [$];
    logic         pop_f7 [$];

    int          lat;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;
    bit          ovr_en;
    logic [31:0] ovr_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0030_8133;
            default:       return {a[26:2], 7'b0110011};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then after the edge update model and memory.
    task automatic tick();
        bit           hs;
        bit           ps;
        logic [31:0]  a;
        logic [31:0]  d;
        fetch_entry_t e;
        @(negedge clk);
        hs = bus.imem_req_valid && bus.imem_req_ready;
        a  = bus.imem_req_addr;
        ps = pc_src;
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_pop: observed pc %h instr %h expected no entry", bus.instr_pc, bus.instr);
            end else begin
                e = sb.pop_front();
                chk("instr",    bus.instr,            e.instr);
                chk("instr_pc", bus.instr_pc,         e.pc);
                chk("pc_plus4", bus.pc_plus4,         e.pc + 32'd4);
                chk("op",       {25'd0, bus.op},      {25'd0, e.instr[6:0]});
                chk("funct3",   {29'd0, bus.funct3},  {29'd0, e.instr[14:12]});
                chk("funct7b5", {31'd0, bus.funct7b5}, {31'd0, e.instr[30]});
            end
            pop_pc.push_back(bus.instr_pc);
            pop_instr.push_back(bus.instr);
            pop_p4.push_back(bus.pc_plus4);
            pop_op.push_back(bus.op);
            pop_f7.push_back(bus.funct7b5);
        end
        if (hs) req_log.push_back(a);
        @(posedge clk);
        #1;
        if (ps) sb.delete();
        if (hs) begin
            d      = ovr_en ? ovr_data : mem_word(a);
            ovr_en = 1'b0;
            if (!ps) begin
                e.instr = d;
                e.pc    = a;
                sb.push_back(e);
            end
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_data = d;
        end
        bus.imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = pend_data;
                pend               = 1'b0;
            end
        end
        pc_src = 1'b0;
    endtask

    task automatic run_pops(input int n, input int budget, input string tag);
        int target;
        target = pop_pc.size() + n;
        for (int i = 0; i < budget && pop_pc.size() < target; i++) tick();
        if (pop_pc.size() < target) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout: observed %0d pops expected %0d", tag, pop_pc.size(), target);
        end
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        pc_src             = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        pend               = 1'b0;
        ovr_en             = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        req_log.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_p4.delete();
        pop_op.delete();
        pop_f7.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        lat         = 1;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_data   = '0;
        ovr_en      = 1'b0;
        ovr_data    = '0;
        reset       = 1'b1;
        pc_src      = 1'b0;
        pc_target   = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b1;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, bus.instr_valid},   32'd0);
        chk("rst_misaligned", {31'd0, misaligned},         32'd0);
        chk("rst_instr",      bus.instr,                   32'd0);
        chk("rst_instr_pc",   bus.instr_pc,                32'd0);
        chk("rst_op",         {25'd0, bus.op},             32'd0);
        do_reset();

        // basic stream, 1-cycle memory
        run_pops(2, 20, "t1");
        chk("t1_req0",  req_log[0], 32'h0);
        chk("t1_req1",  req_log[1], 32'h4);
        chk("t1_pc0",   pop_pc[0],  32'h0);
        chk("t1_pc1",   pop_pc[1],  32'h4);
        chk("t1_op0",   {25'd0, pop_op[0]}, {25'd0, 7'b0010011});
        chk("t1_op1",   {25'd0, pop_op[1]}, {25'd0, 7'b0110011});
        chk("t1_f7_0",  {31'd0, pop_f7[0]}, 32'd0);
        chk("t1_f7_1",  {31'd0, pop_f7[1]}, 32'd0);

        // backpressure fills the buffer, then one pop re-enables issue
        do_reset();
        bus.instr_ready = 1'b0;
        repeat (6) tick();
        chk("t2_full_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("t2_head_valid",     {31'd0, bus.instr_valid},    32'd1);
        chk("t2_head_pc",        bus.instr_pc,                32'h0);
        chk("t2_head_instr",     bus.instr,                   32'h0050_0093);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("t2_req_count",      req_log.size(),              32'd2);
        chk("t2_req_valid_next", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("t2_req_addr_next",  bus.imem_req_addr,           32'h8);
        tick();
        bus.instr_ready = 1'b1;
        run_pops(2, 20, "t2");
        chk("t2_pc1", pop_pc[1], 32'h4);
        chk("t2_pc2", pop_pc[2], 32'h8);

        // redirect while waiting, stale word arrives afterwards
        do_reset();
        lat      = 2;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        tick();
        pc_src    = 1'b1;
        pc_target = 32'h100;
        tick();
        chk("t3_flush_valid", {31'd0, bus.instr_valid}, 32'd0);
        lat = 1;
        run_pops(1, 20, "t3");
        chk("t3_req_target", req_log[1],   32'h100);
        chk("t3_pop_pc",     pop_pc[0],    32'h100);
        chk("t3_pop_instr",  pop_instr[0], mem_word(32'h100));

        // redirect coincides with the response
        do_reset();
        tick();
        pc_src    = 1'b1;
        pc_target = 32'h200;
        tick();
        chk("t4_instr_valid", {31'd0, bus.instr_valid},    32'd0);
        chk("t4_req_valid",   {31'd0, bus.imem_req_valid}, 32'd1);
        chk("t4_req_addr",    bus.imem_req_addr,           32'h200);
        run_pops(1, 20, "t4");
        chk("t4_pop_pc", pop_pc[0], 32'h200);

        // misaligned target is aligned for fetch and flagged stickily
        do_reset();
        pc_src    = 1'b1;
        pc_target = 32'h102;
        tick();
        chk("t5_misaligned", {31'd0, misaligned}, 32'd1);
        run_pops(1, 20, "t5");
        chk("t5_req_addr", req_log[1], 32'h100);
        chk("t5_pop_pc",   pop_pc[0],  32'h100);
        repeat (10) tick();
        chk("t5_misaligned_sticky", {31'd0, misaligned}, 32'd1);
        do_reset();
        chk("t5_misaligned_reset", {31'd0, misaligned}, 32'd0);

        // PC wrap at the top of the address space
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        tick();
        run_pops(2, 20, "t6");
        chk("t6_req_top",  req_log[1], 32'hFFFF_FFFC);
        chk("t6_req_wrap", req_log[2], 32'h0);
        chk("t6_pc0",      pop_pc[0],  32'hFFFF_FFFC);
        chk("t6_p4_0",     pop_p4[0],  32'h0);
        chk("t6_pc1",      pop_pc[1],  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer side of the instruction/decode interface: holds the PC, fetches 32-bit RV32I words from instruction memory over a valid/ready request channel, and presents them to decode with a valid/ready handshake.
- Pre-splits the fields decode consumes (op, funct3, funct7b5).
- Accepts PC redirects (pc_src + target) from execute and flushes any wrong-path state.
- Sits between instruction memory and the control unit / register-file read stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_src  in  1  redirect strobe, 1 cycle.
- pc_target  in  32  redirect address, valid when pc_src=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address of request; bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; exactly one per accepted request, arriving 1 or more cycles later, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of head.
- pc_plus4  out  32  instr_pc + 4, modulo 2^32.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7b5  out  1  instr[30].
- misaligned  out  1  sticky; set when a redirect target has bits [1:0] != 0.

Behaviour:
- Reset (sync, active-high) values:
  - pc = RESET_PC, buffer empty, state REQ.
  - imem_req_valid=0 in the reset cycle; instr_valid=0; misaligned=0.
  - instr, instr_pc, op, funct3 and funct7b5 read 0 when the buffer is empty.
- State machine (at most one outstanding request):
  - REQ:
    - imem_req_valid=1 iff (buffer count) < BUF_DEPTH, counting the slot reserved for the in-flight request.
    - imem_req_addr=pc.
    - On handshake (valid & ready): go to WAIT; pc_inflight=pc; pc=pc+4.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid: push {imem_rsp_data, pc_inflight} into the buffer; go to REQ.
  - DISCARD:
    - imem_req_valid=0.
    - On imem_rsp_valid: drop the data; go to REQ.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency (request cycle, then response cycle). No request is issued in the response cycle.
- Buffer: FIFO of BUF_DEPTH entries. Push and pop in the same cycle are legal at any occupancy, including full (count stays unchanged).
- Pop occurs on instr_valid & instr_ready; the head is held stable while instr_ready=0.
- Redirect (pc_src=1), highest priority, takes effect at the clock edge:
  - pc = {pc_target[31:2], 2'b00}.
  - Buffer is flushed, and instr_valid=0 on the next cycle.
  - If a request is in flight (state WAIT, or a REQ handshake in this same cycle), go to DISCARD; else go to REQ.
  - A response arriving in the same cycle as pc_src is discarded; the state then goes to REQ.
  - A pop in the same cycle as pc_src still completes (decode consumed it); the buffer is empty afterwards.
  - If pc_target[1:0] != 0, set misaligned, which stays 1 until reset.
- Reset mid-operation: all state returns to reset values. Any response arriving after reset without a post-reset request is ignored; state REQ accepts no rsp.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- instr_pc and pc_plus4 are combinational from the head entry; op, funct3 and funct7b5 are combinational slices of instr.

Decomposition:
- Shared package rv_pkg:
  - opcode constants (OP_R 7'b0110011, OP_I 7'b0010011, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL).
  - NOP = 32'h0000_0013.
  - field bit positions.
  - fetch state enum {REQ, WAIT, DISCARD}.
- Sub-module fetch_buffer: parameterised synchronous FIFO (data 64 bits = instr + pc) with push, pop, flush, count, full and empty.
  - Flush has priority over push.
  - Flush does not block a same-cycle pop.

Test Plan:
- Reset, then imem 1-cycle latency returning 32'h00500093, 32'h00308133, with instr_ready=1:
  - requests go to addresses 0x0, 0x4.
  - instr_pc = 0x0, 0x4.
  - op = 7'b0010011 then 7'b0110011; funct7b5 = 0 on both.
- instr_ready=0, BUF_DEPTH=2:
  - After two responses, imem_req_valid stays 0 and instr/instr_pc hold 0x0.
  - Raising instr_ready pops one entry and the next request (addr 0x8) issues the following cycle.
- Redirect pc_src=1, pc_target=0x100, while in WAIT with rsp data 32'hDEADBEEF arriving next cycle:
  - that word is never presented.
  - The next request addr = 0x100; the next instr_pc = 0x100.
- pc_src and imem_rsp_valid in the same cycle:
  - the response is dropped and instr_valid=0 next cycle.
  - A request to the target is issued the following cycle.
- pc_target = 0x102:
  - imem_req_addr = 0x100 and misaligned = 1.
  - misaligned is still 1 after 10 further cycles, and 0 after reset.
- Redirect to 0xFFFFFFFC: fetch addresses are 0xFFFFFFFC then 0x00000000, and pc_plus4 of the first instruction = 0x0.
